b01_result_packer: RTL and testbench

- Downstream consumer of the b01 serial flag comparator.
- Samples b01's per-cycle serial result bit (OUTP) and overflow flag (OVERFLW) and deserialises the result bits into WIDTH-bit words.
- Counts overflow events per word.
- Presents completed words through a DEPTH-entry buffer with a valid/ready handshake.
- Intended as the capture stage for comparator results in the fault-tuple testcase set.

---
 rtl/b01_result_packer.sv | 193 +++++++++++++++++++
 tb/tb_b01_result_packer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/b01_result_packer.sv
// b01_result_packer: capture stage for the b01 serial flag comparator.
// Deserialises OUTP_IN (bit 0 first) into WIDTH-bit words framed by FRAME_START,
// counts OVF_IN events per word (saturating) and queues completed words in a
// DEPTH-entry registered FIFO with a valid/ready handshake.
//
// Ports:
//   CK, RN          clock, asynchronous active-low reset
//   OUTP_IN, OVF_IN serial result bit / overflow flag, qualified by IN_EN
//   IN_EN           input sample valid this cycle
//   FRAME_START     with IN_EN: current bit is bit 0 of a new word
//   DATA_OUT        head word (0 when empty)
//   OVF_CNT_OUT     overflow count of the head word (0 when empty)
//   VALID_OUT       buffer non-empty
//   READY_IN        consumer takes the head word when VALID_OUT=1
//   DROP_OUT        one-cycle pulse: completed word discarded, buffer full
//   PAR_OUT         (B01_PACK_PARITY_EN only) XOR parity of the head word
//
// Optional feature macro: B01_PACK_PARITY_EN
module b01_result_packer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             OUTP_IN,
  input  logic             OVF_IN,
  input  logic             IN_EN,
  input  logic             FRAME_START,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic [CNT_W-1:0] OVF_CNT_OUT,
  output logic             VALID_OUT,
  input  logic             READY_IN,
`ifdef B01_PACK_PARITY_EN
  output logic             PAR_OUT,
`endif
  output logic             DROP_OUT
);

  localparam int unsigned BIT_W = $clog2(WIDTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, COLLECT} state_t;

  // Collector state
  state_t           state;
  logic [BIT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] ovf_cnt;

  // FIFO storage; entry 0 is the head, unused entries are kept at zero
  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [CNT_W-1:0] mem_ovf  [DEPTH];
  logic             mem_vld  [DEPTH];
`ifdef B01_PACK_PARITY_EN
  logic             mem_par  [DEPTH];
`endif
  logic [OCC_W-1:0] occ;

  // Collector decode
  logic             start_c;
  logic             shift_c;
  logic             last_c;
  logic [WIDTH-1:0] word_c;
  logic [CNT_W-1:0] ovf_next_c;

  always_comb begin
    start_c    = IN_EN & FRAME_START;
    shift_c    = (state == COLLECT) & IN_EN & ~FRAME_START;
    last_c     = shift_c & (bit_cnt == BIT_W'(WIDTH - 1));
    word_c     = shreg;
    word_c[bit_cnt] = OUTP_IN;
    ovf_next_c = (OVF_IN && (ovf_cnt != CNT_MAX)) ? ovf_cnt + CNT_W'(1) : ovf_cnt;
  end

  // Collector FSM: a FRAME_START restart wins over shifting in either state
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      ovf_cnt <= '0;
    end else if (start_c) begin
      state   <= COLLECT;
      bit_cnt <= BIT_W'(1);
      shreg   <= WIDTH'(OUTP_IN);
      ovf_cnt <= CNT_W'(OVF_IN);
    end else if (shift_c) begin
      if (last_c) begin
        // Continuous framing: stay in COLLECT, next valid bit is bit 0
        bit_cnt <= '0;
        shreg   <= '0;
        ovf_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + BIT_W'(1);
        shreg   <= word_c;
        ovf_cnt <= ovf_next_c;
      end
    end
  end

  // FIFO next-state: pop shifts entries toward the head, push fills the tail
  logic             pop_c;
  logic             push_ok_c;
  logic             drop_c;
  logic [OCC_W-1:0] widx_c;
  logic [OCC_W-1:0] occ_nxt_c;
  logic [WIDTH-1:0] nxt_data [DEPTH];
  logic [CNT_W-1:0] nxt_ovf  [DEPTH];
  logic             nxt_vld  [DEPTH];
`ifdef B01_PACK_PARITY_EN
  logic             nxt_par  [DEPTH];
`endif

  always_comb begin
    nxt_data = mem_data;
    nxt_ovf  = mem_ovf;
    nxt_vld  = mem_vld;
`ifdef B01_PACK_PARITY_EN
    nxt_par  = mem_par;
`endif
    pop_c     = mem_vld[0] & READY_IN;
    push_ok_c = last_c & ((occ != OCC_W'(DEPTH)) | pop_c);
    drop_c    = last_c & ~push_ok_c;
    widx_c    = pop_c ? occ - OCC_W'(1) : occ;
    occ_nxt_c = occ + OCC_W'(push_ok_c) - OCC_W'(pop_c);

    if (pop_c) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        nxt_data[i] = mem_data[i+1];
        nxt_ovf[i]  = mem_ovf[i+1];
        nxt_vld[i]  = mem_vld[i+1];
`ifdef B01_PACK_PARITY_EN
        nxt_par[i]  = mem_par[i+1];
`endif
      end
      nxt_data[DEPTH-1] = '0;
      nxt_ovf[DEPTH-1]  = '0;
      nxt_vld[DEPTH-1]  = 1'b0;
`ifdef B01_PACK_PARITY_EN
      nxt_par[DEPTH-1]  = 1'b0;
`endif
    end

    if (push_ok_c) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (OCC_W'(i) == widx_c) begin
          nxt_data[i] = word_c;
          nxt_ovf[i]  = ovf_next_c;
          nxt_vld[i]  = 1'b1;
`ifdef B01_PACK_PARITY_EN
          nxt_par[i]  = ^word_c;
`endif
        end
      end
    end
  end

  // FIFO registers and drop pulse
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_data[i] <= '0;
        mem_ovf[i]  <= '0;
        mem_vld[i]  <= 1'b0;
`ifdef B01_PACK_PARITY_EN
        mem_par[i]  <= 1'b0;
`endif
      end
      occ      <= '0;
      DROP_OUT <= 1'b0;
    end else begin
      mem_data <= nxt_data;
      mem_ovf  <= nxt_ovf;
      mem_vld  <= nxt_vld;
`ifdef B01_PACK_PARITY_EN
      mem_par  <= nxt_par;
`endif
      occ      <= occ_nxt_c;
      DROP_OUT <= drop_c;
    end
  end

  // Outputs come straight from the head-entry registers
  assign DATA_OUT    = mem_data[0];
  assign OVF_CNT_OUT = mem_ovf[0];
  assign VALID_OUT   = mem_vld[0];
`ifdef B01_PACK_PARITY_EN
  assign PAR_OUT     = mem_par[0];
`endif

endmodule

// File: tb/tb_b01_result_packer.sv
// Scoreboard bench for b01_result_packer (WIDTH=8, CNT_W=2, DEPTH=2).
module tb_b01_result_packer;

  localparam int W    = 8;
  localparam int CW   = 2;
  localparam int DEP  = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          CK = 1'b0;
  logic          RN = 1'b0;
  logic          OUTP_IN = 1'b0;
  logic          OVF_IN = 1'b0;
  logic          IN_EN = 1'b0;
  logic          FRAME_START = 1'b0;
  logic          READY_IN = 1'b0;
  logic [W-1:0]  DATA_OUT;
  logic [CW-1:0] OVF_CNT_OUT;
  logic          VALID_OUT;
  logic          DROP_OUT;
`ifdef B01_PACK_PARITY_EN
  logic          PAR_OUT;
`endif

  b01_result_packer #(.WIDTH(W), .CNT_W(CW), .DEPTH(DEP)) dut (
    .CK(CK), .RN(RN), .OUTP_IN(OUTP_IN), .OVF_IN(OVF_IN), .IN_EN(IN_EN),
    .FRAME_START(FRAME_START), .DATA_OUT(DATA_OUT), .OVF_CNT_OUT(OVF_CNT_OUT),
    .VALID_OUT(VALID_OUT), .READY_IN(READY_IN),
`ifdef B01_PACK_PARITY_EN
    .PAR_OUT(PAR_OUT),
`endif
    .DROP_OUT(DROP_OUT)
  );

  always #5 CK = ~CK;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: bit list per frame, plain occupancy count for the buffer
  typedef struct {
    logic [W-1:0] d;
    int           o;
  } exp_t;

  exp_t exp_q[$];
  bit   mbits[$];
  bit   mactive;
  int   movf;
  int   mocc;
  bit   mdrop;

  always @(posedge CK or negedge RN) begin
    bit   mpop;
    bit   done;
    exp_t e;
    if (!RN) begin
      mbits.delete();
      mactive = 0;
      movf    = 0;
      mocc    = 0;
      mdrop   = 0;
      exp_q.delete();
    end else begin
      mpop  = (mocc > 0) && READY_IN;
      done  = 0;
      mdrop = 0;
      if (IN_EN) begin
        if (FRAME_START) begin
          mbits.delete();
          mbits.push_back(OUTP_IN);
          movf    = int'(OVF_IN);
          mactive = 1;
        end else if (mactive) begin
          mbits.push_back(OUTP_IN);
          if (OVF_IN && movf < CMAX) movf++;
        end
        if (mbits.size() == W) begin
          for (int i = 0; i < W; i++) e.d[i] = mbits[i];
          e.o  = movf;
          done = 1;
          mbits.delete();
          movf = 0;
        end
      end
      if (done && !mpop && mocc == DEP) mdrop = 1;
      if (mpop) mocc--;
      if (done && !mdrop) begin
        mocc++;
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: per-cycle handshake flags, in-order word comparison on pop
  always @(negedge CK) begin
    exp_t e;
    if (RN) begin
      chk("valid", int'(VALID_OUT), int'(mocc > 0));
      chk("drop", int'(DROP_OUT), int'(mdrop));
      if (VALID_OUT) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 1, 0);
        end else begin
          e = exp_q[0];
          if (READY_IN) void'(exp_q.pop_front());
          chk("data", int'(DATA_OUT), int'(e.d));
          chk("ovf_cnt", int'(OVF_CNT_OUT), e.o);
`ifdef B01_PACK_PARITY_EN
          chk("parity", int'(PAR_OUT), int'(^e.d));
`endif
        end
      end else begin
        chk("empty_data", int'(DATA_OUT), 0);
        chk("empty_ovf", int'(OVF_CNT_OUT), 0);
`ifdef B01_PACK_PARITY_EN
        chk("empty_par", int'(PAR_OUT), 0);
`endif
      end
    end
  end

  // One cycle of stimulus, applied just after the active edge
  task automatic cyc(input logic en, input logic fs, input logic b, input logic ov,
                     input logic rdy);
    @(posedge CK);
    #1;
    IN_EN       = en;
    FRAME_START = fs;
    OUTP_IN     = b;
    OVF_IN      = ov;
    READY_IN    = rdy;
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic ov, input int gap,
                           input logic rdy, input logic last_rdy);
    for (int i = 0; i < W; i++) begin
      if (i > 0) repeat (gap) cyc(1'b0, 1'b0, 1'b0, 1'b0, rdy);
      cyc(1'b1, i == 0, w[i], ov, (i == W - 1) ? last_rdy : rdy);
    end
  endtask

  task automatic flush();
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk_outs_zero(input string nm);
    chk({nm, "_valid"}, int'(VALID_OUT), 0);
    chk({nm, "_data"}, int'(DATA_OUT), 0);
    chk({nm, "_ovf"}, int'(OVF_CNT_OUT), 0);
    chk({nm, "_drop"}, int'(DROP_OUT), 0);
  endtask

  initial begin
    logic [W-1:0] partial;
    // Reset state
    #1;
    chk_outs_zero("reset");
    repeat (2) @(posedge CK);
    #1;
    RN = 1'b1;

    // Bits without FRAME_START are ignored
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ignored_valid", int'(VALID_OUT), 0);

    // 0x4D, visible one cycle after the completion edge
    send_word(8'h4D, 1'b0, 0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("w4d_valid", int'(VALID_OUT), 1);
    chk("w4d_data", int'(DATA_OUT), 'h4D);
    chk("w4d_ovf", int'(OVF_CNT_OUT), 0);

    // Overflow saturation, without and with IN_EN gaps
    send_word(8'hA5, 1'b1, 0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("sat_valid", int'(VALID_OUT), 1);
    chk("sat_ovf", int'(OVF_CNT_OUT), 3);
    send_word(8'h3C, 1'b1, 3, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("sat_gap_data", int'(DATA_OUT), 'h3C);
    chk("sat_gap_ovf", int'(OVF_CNT_OUT), 3);
    flush();

    // Three words with READY_IN low: third is dropped
    send_word(8'h11, 1'b0, 0, 1'b0, 1'b0);
    send_word(8'h22, 1'b1, 0, 1'b0, 1'b0);
    send_word(8'h33, 1'b0, 0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("drop_pulse", int'(DROP_OUT), 1);
    chk("drop_head", int'(DATA_OUT), 'h11);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("drop_once", int'(DROP_OUT), 0);
    flush();
    chk("drained_valid", int'(VALID_OUT), 0);

    // Full buffer, completion on a pop edge: no drop
    send_word(8'h44, 1'b0, 0, 1'b0, 1'b0);
    send_word(8'h55, 1'b0, 0, 1'b0, 1'b0);
    send_word(8'h66, 1'b1, 0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fullpop_drop", int'(DROP_OUT), 0);
    chk("fullpop_head", int'(DATA_OUT), 'h55);
    flush();

    // Restart after 5 bits, then 0xFF
    partial = 8'h0F;
    for (int i = 0; i < 5; i++) cyc(1'b1, i == 0, partial[i], 1'b1, 1'b1);
    send_word(8'hFF, 1'b0, 0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("restart_drop", int'(DROP_OUT), 0);
    chk("restart_data", int'(DATA_OUT), 'hFF);
    chk("restart_ovf", int'(OVF_CNT_OUT), 0);
    flush();

    // Reset mid-word with a buffered word
    send_word(8'h5A, 1'b1, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, i == 0, 1'b1, 1'b0, 1'b0);
    @(posedge CK);
    #3;
    RN = 1'b0;
    #1;
    chk_outs_zero("async_reset");
    repeat (2) @(posedge CK);
    #1;
    RN = 1'b1;
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("post_reset_valid", int'(VALID_OUT), 0);

    // Random traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(99) < 70, $urandom_range(99) < 5, 1'($urandom),
          1'($urandom), $urandom_range(99) < 60);

    // Bounded drain
    for (int i = 0; i < 20 && exp_q.size() > 0; i++)
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("drain_left", exp_q.size(), 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("final_valid", int'(VALID_OUT), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
